// File: rtl/timer_pkg.sv
// Shared types and constants for the minutes:seconds timer family.
// No logic; pure declarations.
// Not applicable (package).
package timer_pkg;

    localparam int MIN_W  = 7;
    localparam int SEC_W  = 6;
    localparam int TIME_W = MIN_W + SEC_W;

    // Typed so comparisons against seconds fields stay width-matched.
    localparam logic [SEC_W-1:0] MAX_SEC = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_t;

    // Packed so minutes occupy [12:6] and seconds [5:0] of the bus.
    typedef struct packed {
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } mmss_t;

endpackage

// File: rtl/mmss_decrement.sv
// Borrow-decrement of a minutes:seconds value, with a zero flag for the result.
// Combinational, zero latency.
// No flow control; an input of 00:00 is passed through unchanged (never wraps).
module mmss_decrement
    import timer_pkg::*;
(
    input  mmss_t val_i,
    output mmss_t val_o,
    output logic  zero_o
);

    // Seconds count down first; an empty seconds field borrows one minute.
    always_comb begin
        val_o = val_i;
        if (val_i.sec != '0) begin
            val_o.sec = val_i.sec - SEC_W'(1);
        end else if (val_i.min != '0) begin
            val_o.min = val_i.min - MIN_W'(1);
            val_o.sec = MAX_SEC;
        end
    end

    assign zero_o = (val_o == '0);

endmodule

// File: rtl/countdown_timer.sv
// Loadable mm:ss countdown timer; optional AUTO_RELOAD_EN restarts from the preset at 00:00.
// time_out updates one clk after the tick cycle; load/clear act on the next clk edge.
// No backpressure; load is ignored while running, a tick is dropped in the cycle enable falls.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int MAX_MIN = 99
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              clock_div,
    input  logic              load,
    input  logic [TIME_W-1:0] preset_in,
    input  logic              enable,
    input  logic              clear,
    output logic [TIME_W-1:0] time_out,
    output logic              running,
    output logic              done,
    output logic              expired
);

    localparam logic [MIN_W-1:0] MAX_MIN_L = MIN_W'(MAX_MIN);

    timer_state_t state_q, state_d;
    mmss_t        time_q, time_d;
    mmss_t        preset_q, preset_d;
    logic         expired_q, expired_d;

    mmss_t        preset_raw;
    mmss_t        preset_sat;
    mmss_t        time_dec;
    logic         dec_zero;

    assign preset_raw = mmss_t'(preset_in);

    // Clamp out-of-range preset fields to the largest legal value.
    always_comb begin
        preset_sat.min = (preset_raw.min > MAX_MIN_L) ? MAX_MIN_L : preset_raw.min;
        preset_sat.sec = (preset_raw.sec > MAX_SEC)   ? MAX_SEC   : preset_raw.sec;
    end

    mmss_decrement u_dec (
        .val_i  (time_q),
        .val_o  (time_dec),
        .zero_o (dec_zero)
    );

    // Next-state, time and preset update with priority clear > load > enable/tick.
    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        preset_d  = preset_q;
        expired_d = 1'b0;

        if (clear) begin
            state_d  = ST_IDLE;
            time_d   = '0;
            preset_d = '0;
        end else if (load && (state_q != ST_RUN)) begin
            state_d  = ST_IDLE;
            time_d   = preset_sat;
            preset_d = preset_sat;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // A zero time never starts counting.
                    if (enable && (time_q != '0)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        // Tick in the pausing cycle is deliberately discarded.
                        state_d = ST_PAUSE;
                    end else if (clock_div && (time_q != '0)) begin
                        if (dec_zero) begin
                            expired_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                            time_d    = preset_q;
`else
                            time_d    = '0;
                            state_d   = ST_DONE;
`endif
                        end else begin
                            time_d = time_dec;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (enable) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    time_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, time, preset and expired-pulse registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            time_q    <= '0;
            preset_q  <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            preset_q  <= preset_d;
            expired_q <= expired_d;
        end
    end

    assign time_out = time_q;
    assign running  = (state_q == ST_RUN);
`ifdef AUTO_RELOAD_EN
    assign done     = 1'b0;
`else
    assign done     = (state_q == ST_DONE);
`endif
    assign expired  = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a cycle-tagged expectation queue.
// Stimulus pushes expectations; a negedge monitor pops and compares them.
// Not applicable (testbench).
module tb_countdown_timer;

    logic        clk;
    logic        nrst;
    logic        clock_div;
    logic        load;
    logic [12:0] preset_in;
    logic        enable;
    logic        clear;
    logic [12:0] time_out;
    logic        running;
    logic        done;
    logic        expired;

    typedef struct {
        int          cyc;
        logic [12:0] t;
        logic        r;
        logic        d;
        logic        e;
    } exp_t;

    exp_t  expq[$];
    string nameq[$];
    int    cyc;
    int    checks;
    int    errors;

    countdown_timer #(.MAX_MIN(99)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .clock_div (clock_div),
        .load      (load),
        .preset_in (preset_in),
        .enable    (enable),
        .clear     (clear),
        .time_out  (time_out),
        .running   (running),
        .done      (done),
        .expired   (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [12:0] mm(input int m, input int s);
        logic [6:0] mv;
        logic [5:0] sv;
        mv = 7'(m);
        sv = 6'(s);
        return {mv, sv};
    endfunction

    task automatic expect_out(input string nm, input logic [12:0] t,
                              input logic r, input logic d, input logic e);
        exp_t x;
        x.cyc = cyc;
        x.t   = t;
        x.r   = r;
        x.d   = d;
        x.e   = e;
        expq.push_back(x);
        nameq.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        clock_div = 1'b1;
        step();
        clock_div = 1'b0;
    endtask

    task automatic do_load(input logic [12:0] p);
        load      = 1'b1;
        preset_in = p;
        step();
        load      = 1'b0;
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (expq.size() > 0 && expq[0].cyc <= cyc) begin
            exp_t  x;
            string nm;
            x  = expq.pop_front();
            nm = nameq.pop_front();
            checks++;
            if (time_out !== x.t || running !== x.r || done !== x.d || expired !== x.e) begin
                errors++;
                $display("FAIL %s: got time=%02d:%02d run=%b done=%b exp=%b, want time=%02d:%02d run=%b done=%b exp=%b",
                         nm, time_out[12:6], time_out[5:0], running, done, expired,
                         x.t[12:6], x.t[5:0], x.r, x.d, x.e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        nrst      = 1'b0;
        clock_div = 1'b0;
        load      = 1'b0;
        preset_in = '0;
        enable    = 1'b0;
        clear     = 1'b0;

        step();
        expect_out("reset", mm(0, 0), 0, 0, 0);
        step();
        nrst = 1'b1;
        step();
        expect_out("idle_after_reset", mm(0, 0), 0, 0, 0);

        // Load 01:05 and count six ticks across a minute borrow.
        do_load(mm(1, 5));
        expect_out("load_0105", mm(1, 5), 0, 0, 0);
        enable = 1'b1;
        step();
        expect_out("start_run", mm(1, 5), 1, 0, 0);
        tick();
        expect_out("tick1_0104", mm(1, 4), 1, 0, 0);
        tick(); tick(); tick();
        expect_out("tick4_0101", mm(1, 1), 1, 0, 0);
        tick();
        expect_out("tick5_0100", mm(1, 0), 1, 0, 0);
        tick();
        expect_out("tick6_0059", mm(0, 59), 1, 0, 0);
        step();
        expect_out("hold_no_tick", mm(0, 59), 1, 0, 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        expect_out("clear_in_run", mm(0, 0), 0, 0, 0);
        enable = 1'b0;

`ifndef AUTO_RELOAD_EN
        // 00:02 down to DONE; tick in the start cycle must not count.
        do_load(mm(0, 2));
        expect_out("load_0002", mm(0, 2), 0, 0, 0);
        enable    = 1'b1;
        clock_div = 1'b1;
        step();
        clock_div = 1'b0;
        expect_out("start_tick_ignored", mm(0, 2), 1, 0, 0);
        tick();
        expect_out("run_0001", mm(0, 1), 1, 0, 0);
        tick();
        expect_out("done_entry", mm(0, 0), 0, 1, 1);
        step();
        expect_out("expired_one_clk", mm(0, 0), 0, 1, 0);
        tick();
        expect_out("done_hold_tick", mm(0, 0), 0, 1, 0);
        enable = 1'b0;
`else
        // Auto-reload: two periods of 00:02, done never asserted.
        do_load(mm(0, 2));
        enable = 1'b1;
        step();
        expect_out("ar_start", mm(0, 2), 1, 0, 0);
        tick();
        expect_out("ar_0001", mm(0, 1), 1, 0, 0);
        tick();
        expect_out("ar_reload1", mm(0, 2), 1, 0, 1);
        step();
        expect_out("ar_pulse_end", mm(0, 2), 1, 0, 0);
        tick();
        expect_out("ar_0001b", mm(0, 1), 1, 0, 0);
        tick();
        expect_out("ar_reload2", mm(0, 2), 1, 0, 1);
        enable = 1'b0;
        step();
        expect_out("ar_pause", mm(0, 2), 0, 0, 0);
`endif

        // Pause drops the tick of the pausing cycle and all paused ticks.
        do_load(mm(0, 10));
        expect_out("load_0010", mm(0, 10), 0, 0, 0);
        enable = 1'b1;
        step();
        tick(); tick(); tick();
        expect_out("run_0007", mm(0, 7), 1, 0, 0);
        enable = 1'b0;
        tick();
        expect_out("pause_tick_dropped", mm(0, 7), 0, 0, 0);
        tick(); tick(); tick(); tick();
        expect_out("paused_hold", mm(0, 7), 0, 0, 0);
        enable = 1'b1;
        step();
        expect_out("resume", mm(0, 7), 1, 0, 0);
        tick();
        expect_out("resume_0006", mm(0, 6), 1, 0, 0);
        do_load(mm(3, 3));
        expect_out("load_in_run_ignored", mm(0, 6), 1, 0, 0);
        enable = 1'b0;
        step();

        // Saturation, load+clear priority, zero time cannot start.
        do_load({7'd100, 6'd63});
        expect_out("sat_9959", mm(99, 59), 0, 0, 0);
        do_load({7'd5, 6'd60});
        expect_out("sat_sec_0559", mm(5, 59), 0, 0, 0);
        load      = 1'b1;
        clear     = 1'b1;
        preset_in = mm(7, 7);
        step();
        load      = 1'b0;
        clear     = 1'b0;
        expect_out("clear_beats_load", mm(0, 0), 0, 0, 0);
        enable = 1'b1;
        step();
        expect_out("zero_no_run", mm(0, 0), 0, 0, 0);
        enable = 1'b0;

        // Asynchronous reset mid-count.
        do_load(mm(0, 31));
        enable = 1'b1;
        step();
        tick();
        expect_out("run_0030", mm(0, 30), 1, 0, 0);
        step();
        #1;
        nrst = 1'b0;
        expect_out("async_reset", mm(0, 0), 0, 0, 0);
        step();
        nrst = 1'b1;
        step();
        expect_out("after_reset", mm(0, 0), 0, 0, 0);
        enable = 1'b0;

        // Let the monitor drain within a bounded number of cycles.
        for (int i = 0; i < 4 && expq.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", expq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
